forwarding_unit: RTL and testbench



---
 rtl/forwarding_unit_if.sv | 33 +++
 rtl/forwarding_unit.sv | 89 ++++++++
 tb/tb_forwarding_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/forwarding_unit_if.sv
// Signal bundle between the pipeline datapath and the forwarding unit.
// The datapath side is the master; the forwarding unit is the slave.
interface forwarding_unit_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        ex_regWrite;
  logic        mem_regWrite;
  logic        wb_regWrite;
  logic        id_branch;
  logic [1:0]  ex_muxA;
  logic [1:0]  ex_muxB;
  logic [1:0]  id_muxA;
  logic [1:0]  id_muxB;
  logic [15:0] ex_fwd_count;
  logic [15:0] id_fwd_count;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           ex_regWrite, mem_regWrite, wb_regWrite, id_branch,
    input  ex_muxA, ex_muxB, id_muxA, id_muxB, ex_fwd_count, id_fwd_count
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           ex_regWrite, mem_regWrite, wb_regWrite, id_branch,
    output ex_muxA, ex_muxB, id_muxA, id_muxB, ex_fwd_count, id_fwd_count
  );
endinterface

// File: rtl/forwarding_unit.sv
// Operand forwarding for the 5-stage MIPS pipeline: combinational ALU and
// branch-comparator operand selects plus saturating forwarding-event counters.
module forwarding_unit (
  input  logic              clk,
  input  logic              rst,
  forwarding_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    EX_SEL_RF  = 2'b00,
    EX_SEL_WB  = 2'b01,
    EX_SEL_MEM = 2'b10
  } ex_sel_e;

  typedef enum logic [1:0] {
    ID_SEL_RF  = 2'b00,
    ID_SEL_EX  = 2'b01,
    ID_SEL_MEM = 2'b10,
    ID_SEL_WB  = 2'b11
  } id_sel_e;

  // $0 is hardwired to zero, so it never has a producer worth forwarding.
  function automatic logic match(input logic we, input logic [4:0] rd,
                                 input logic [4:0] r);
    return we && (rd != 5'd0) && (rd == r);
  endfunction

  function automatic ex_sel_e ex_sel(input logic [4:0] r,
                                     input logic mem_we, input logic [4:0] mem_rd,
                                     input logic wb_we,  input logic [4:0] wb_rd);
    if (match(mem_we, mem_rd, r))     return EX_SEL_MEM;
    else if (match(wb_we, wb_rd, r))  return EX_SEL_WB;
    else                              return EX_SEL_RF;
  endfunction

  function automatic id_sel_e id_sel(input logic [4:0] r, input logic br,
                                     input logic ex_we,  input logic [4:0] ex_rd,
                                     input logic mem_we, input logic [4:0] mem_rd,
                                     input logic wb_we,  input logic [4:0] wb_rd);
    if (!br)                            return ID_SEL_RF;
    else if (match(ex_we, ex_rd, r))    return ID_SEL_EX;
    else if (match(mem_we, mem_rd, r))  return ID_SEL_MEM;
    else if (match(wb_we, wb_rd, r))    return ID_SEL_WB;
    else                                return ID_SEL_RF;
  endfunction

  ex_sel_e     ex_a, ex_b;
  id_sel_e     id_a, id_b;
  logic [15:0] ex_fwd_count_q, ex_fwd_count_d;
  logic [15:0] id_fwd_count_q, id_fwd_count_d;

  always_comb begin
    ex_a = ex_sel(bus.ex_rs, bus.mem_regWrite, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
    ex_b = ex_sel(bus.ex_rt, bus.mem_regWrite, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
    id_a = id_sel(bus.id_rs, bus.id_branch, bus.ex_regWrite, bus.ex_rd,
                  bus.mem_regWrite, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
    id_b = id_sel(bus.id_rt, bus.id_branch, bus.ex_regWrite, bus.ex_rd,
                  bus.mem_regWrite, bus.mem_rd, bus.wb_regWrite, bus.wb_rd);
  end

  assign bus.ex_muxA = ex_a;
  assign bus.ex_muxB = ex_b;
  assign bus.id_muxA = id_a;
  assign bus.id_muxB = id_b;

  // One increment per cycle regardless of how many selects are active.
  always_comb begin
    ex_fwd_count_d = ex_fwd_count_q;
    id_fwd_count_d = id_fwd_count_q;
    if ((ex_a != EX_SEL_RF || ex_b != EX_SEL_RF) && ex_fwd_count_q != '1)
      ex_fwd_count_d = ex_fwd_count_q + 16'd1;
    if ((id_a != ID_SEL_RF || id_b != ID_SEL_RF) && id_fwd_count_q != '1)
      id_fwd_count_d = id_fwd_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_fwd_count_q <= '0;
      id_fwd_count_q <= '0;
    end else begin
      ex_fwd_count_q <= ex_fwd_count_d;
      id_fwd_count_q <= id_fwd_count_d;
    end
  end

  assign bus.ex_fwd_count = ex_fwd_count_q;
  assign bus.id_fwd_count = id_fwd_count_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: select vector table plus counter
// sequences (accumulate, reset-wins, multi-select, saturation).
module tb_forwarding_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forwarding_unit_if fu_if ();

  forwarding_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (fu_if)
  );

  typedef struct {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_we, mem_we, wb_we, br;
    logic [1:0] ex_a, ex_b, id_a, id_b;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        vecs[13];

  function automatic vec_t mk(
    input logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
    input logic ex_we, mem_we, wb_we, br,
    input logic [1:0] ex_a, ex_b, id_a, id_b);
    vec_t v;
    v.id_rs = id_rs; v.id_rt = id_rt; v.ex_rs = ex_rs; v.ex_rt = ex_rt;
    v.ex_rd = ex_rd; v.mem_rd = mem_rd; v.wb_rd = wb_rd;
    v.ex_we = ex_we; v.mem_we = mem_we; v.wb_we = wb_we; v.br = br;
    v.ex_a = ex_a; v.ex_b = ex_b; v.id_a = id_a; v.id_b = id_b;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fu_if.id_rs        = v.id_rs;
    fu_if.id_rt        = v.id_rt;
    fu_if.ex_rs        = v.ex_rs;
    fu_if.ex_rt        = v.ex_rt;
    fu_if.ex_rd        = v.ex_rd;
    fu_if.mem_rd       = v.mem_rd;
    fu_if.wb_rd        = v.wb_rd;
    fu_if.ex_regWrite  = v.ex_we;
    fu_if.mem_regWrite = v.mem_we;
    fu_if.wb_regWrite  = v.wb_we;
    fu_if.id_branch    = v.br;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //          id_rs id_rt ex_rs ex_rt ex_rd mem_rd wb_rd exw mw wbw br  exA exB idA idB
    vecs[0]  = mk(0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk(0,  0,  5,  0,  0,  5,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    vecs[2]  = mk(0,  0,  5,  4,  0,  5,  4,  0, 1, 1, 0,  2, 1, 0, 0);
    vecs[3]  = mk(0,  0,  7,  3,  0,  3,  7,  0, 1, 1, 0,  1, 2, 0, 0);
    vecs[4]  = mk(8,  2,  0,  0,  2,  8,  0,  1, 1, 0, 1,  0, 0, 2, 1);
    vecs[5]  = mk(2,  9,  0,  0,  2,  8,  9,  1, 1, 1, 1,  0, 0, 1, 3);
    vecs[6]  = mk(2,  6,  0,  0,  6,  6,  6,  1, 1, 1, 1,  0, 0, 0, 1);
    vecs[7]  = mk(0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0,  0, 0, 0, 0);
    vecs[8]  = mk(3,  0,  0,  0,  3,  0,  0,  1, 0, 0, 0,  0, 0, 0, 0);
    vecs[9]  = mk(0,  0,  4,  0,  4,  0,  0,  1, 0, 0, 0,  0, 0, 0, 0);
    vecs[10] = mk(0,  0,  6,  0,  0,  6,  6,  0, 1, 1, 0,  2, 0, 0, 0);
    vecs[11] = mk(0,  0,  0,  0,  0,  0,  0,  1, 0, 0, 1,  0, 0, 0, 0);
    vecs[12] = mk(12, 0,  0,  0,  12, 12, 12, 0, 1, 1, 1,  0, 0, 2, 0);

    drive(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ex_count", int'(fu_if.ex_fwd_count), 0);
    check("reset_id_count", int'(fu_if.id_fwd_count), 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_ex_muxA", i), int'(fu_if.ex_muxA), int'(vecs[i].ex_a));
      check($sformatf("v%0d_ex_muxB", i), int'(fu_if.ex_muxB), int'(vecs[i].ex_b));
      check($sformatf("v%0d_id_muxA", i), int'(fu_if.id_muxA), int'(vecs[i].id_a));
      check($sformatf("v%0d_id_muxB", i), int'(fu_if.id_muxB), int'(vecs[i].id_b));
    end

    // Selects must not depend on reset.
    @(negedge clk);
    rst = 1'b1;
    drive(vecs[5]);
    #1;
    check("rst_id_muxB", int'(fu_if.id_muxB), 3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    check("clear_ex_count", int'(fu_if.ex_fwd_count), 0);
    check("clear_id_count", int'(fu_if.id_fwd_count), 0);

    // EX-only forwarding held for 5 edges.
    drive(mk(0, 0, 5, 0, 0, 5, 0, 0, 1, 0, 0, 2, 0, 0, 0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("hold5_ex_count", int'(fu_if.ex_fwd_count), 5);
    check("hold5_id_count", int'(fu_if.id_fwd_count), 0);

    // Reset wins over a simultaneous event.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstwin_ex_count", int'(fu_if.ex_fwd_count), 0);
    rst = 1'b0;

    // Several selects active at once still count once per cycle.
    drive(vecs[5]);
    fu_if.ex_rs = 5'd8;
    fu_if.ex_rt = 5'd9;
    #1;
    check("multi_ex_muxA", int'(fu_if.ex_muxA), 2);
    check("multi_ex_muxB", int'(fu_if.ex_muxB), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("multi_ex_count", int'(fu_if.ex_fwd_count), 3);
    check("multi_id_count", int'(fu_if.id_fwd_count), 3);

    // Saturation: 3 events so far, 65540 more overshoots 16'hFFFF.
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("sat_ex_count", int'(fu_if.ex_fwd_count), 16'hFFFF);
    check("sat_id_count", int'(fu_if.id_fwd_count), 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    check("sat_hold_ex_count", int'(fu_if.ex_fwd_count), 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
